// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32 core: steps the shared ALU, memory port, register file
// and PC through fetch/decode/execute/memory/writeback, waiting on MemReady with a bounded timeout.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] WBSel,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal,
  output logic       BusErr
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
    S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_WB_ALU, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic          waiting;
  logic          timeout_hit;

  // True in the last allowed waiting cycle; MemReady in that same cycle still takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    waiting     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    WBSel       = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    InstrDone   = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        waiting = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LUI:       state_d = S_EXEC_LUI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        // IR still holds the same instruction, so re-reading Opcode here is safe.
        state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        waiting = 1'b1;
        if (MemReady) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        waiting  = 1'b1;
        if (MemReady) begin
          InstrDone = 1'b1;
          state_d   = S_FETCH;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        WBSel     = 2'b01;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        InstrDone   = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        // PC already advanced to OldPC+4 in FETCH, so it is the link value.
        PCWrite   = 1'b1;
        PCSource  = 2'b01;
        RegWrite  = 1'b1;
        WBSel     = 2'b10;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && !MemReady && (TIMEOUT != 0) && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign Illegal = illegal_q;
  assign BusErr  = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory stalls, timeout and traps,
// comparing the full control-output vector against hand-written per-state values every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite;
  logic       InstrDone, Illegal, BusErr;
  logic [1:0] PCSource, WBSel, ALUSrcA, ALUSrcB, ALUOp;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b1110011;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .InstrDone(InstrDone), .Illegal(Illegal), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {PCWrite, PCWriteCond, PCSource, IorD, IRWrite, MemRead, MemWrite, RegWrite,
                WBSel, ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, BusErr};

  // Field order: pcw pcwc pcs iord irw mr mw rw wb sa sb op done ill be
  function automatic logic [19:0] v(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                    input logic iord, input logic irw, input logic mr,
                                    input logic mw, input logic rw, input logic [1:0] wb,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] op, input logic done,
                                    input logic ill, input logic be);
    return {pcw, pcwc, pcs, iord, irw, mr, mw, rw, wb, sa, sb, op, done, ill, be};
  endfunction

  logic [19:0] Z, F_W, F_R, DEC, MADDR, MRD, MWR, MWR_D, WBM, EXR, EXI, EXL, WBA, BRV, JALV;
  logic [19:0] TRAP_B, TRAP_I;

  task automatic check(input string tag, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle, check mid-cycle, then advance past the next rising edge.
  task automatic step(input logic [6:0] op, input logic rdy, input logic [19:0] exp,
                      input string tag);
    Opcode   = op;
    MemReady = rdy;
    #2;
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    Z      = '0;
    F_W    = v(0,0,2'b00,0,0,1,0,0,2'b00,2'b00,2'b01,2'b00,0,0,0);
    F_R    = v(1,0,2'b00,0,1,1,0,0,2'b00,2'b00,2'b01,2'b00,0,0,0);
    DEC    = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,0,0);
    MADDR  = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0);
    MRD    = v(0,0,2'b00,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    MWR    = v(0,0,2'b00,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0);
    MWR_D  = v(0,0,2'b00,1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0,0);
    WBM    = v(0,0,2'b00,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,1,0,0);
    EXR    = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b01,2'b00,2'b10,0,0,0);
    EXI    = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b01,2'b10,2'b10,0,0,0);
    EXL    = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b11,2'b10,2'b11,0,0,0);
    WBA    = v(0,0,2'b00,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0,0);
    BRV    = v(0,1,2'b01,0,0,0,0,0,2'b00,2'b01,2'b00,2'b01,1,0,0);
    JALV   = v(1,0,2'b01,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,1,0,0);
    TRAP_B = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0,1);
    TRAP_I = v(0,0,2'b00,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1,0);

    reset    = 1'b1;
    Opcode   = '0;
    MemReady = 1'b0;
    #1;
    check("reset_hold", Z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(7'd0, 1'b0, Z, "rst_state");

    // ADD; Opcode changed during EXEC_R must be ignored
    step(OP_R,  1'b1, F_R, "add_fetch");
    step(OP_R,  1'b0, DEC, "add_decode");
    step(OP_LW, 1'b0, EXR, "add_exec");
    step(OP_LW, 1'b1, WBA, "add_wb");

    step(OP_I,  1'b1, F_R, "addi_fetch");
    step(OP_I,  1'b0, DEC, "addi_decode");
    step(OP_I,  1'b0, EXI, "addi_exec");
    step(OP_I,  1'b0, WBA, "addi_wb");

    step(OP_LUI, 1'b1, F_R, "lui_fetch");
    step(OP_LUI, 1'b0, DEC, "lui_decode");
    step(OP_LUI, 1'b0, EXL, "lui_exec");
    step(OP_LUI, 1'b0, WBA, "lui_wb");

    // LW with MemReady delayed 3 cycles in MEM_RD
    step(OP_LW, 1'b1, F_R,   "lw_fetch");
    step(OP_LW, 1'b0, DEC,   "lw_decode");
    step(OP_LW, 1'b0, MADDR, "lw_addr");
    for (int i = 0; i < 3; i++) step(OP_LW, 1'b0, MRD, "lw_rd_wait");
    step(OP_LW, 1'b1, MRD, "lw_rd_ready");
    step(OP_LW, 1'b0, WBM, "lw_wb");

    // SW with two stall cycles
    step(OP_SW, 1'b1, F_R,   "sw_fetch");
    step(OP_SW, 1'b0, DEC,   "sw_decode");
    step(OP_SW, 1'b0, MADDR, "sw_addr");
    step(OP_SW, 1'b0, MWR,   "sw_wr_wait");
    step(OP_SW, 1'b0, MWR,   "sw_wr_wait");
    step(OP_SW, 1'b1, MWR_D, "sw_wr_ready");

    // Fetch stalls before the branch
    step(OP_BR, 1'b0, F_W, "br_fetch_wait");
    step(OP_BR, 1'b0, F_W, "br_fetch_wait");
    step(OP_BR, 1'b1, F_R, "br_fetch");
    step(OP_BR, 1'b0, DEC, "br_decode");
    step(OP_BR, 1'b0, BRV, "br_branch");

    step(OP_JAL, 1'b1, F_R,  "jal_fetch");
    step(OP_JAL, 1'b0, DEC,  "jal_decode");
    step(OP_JAL, 1'b0, JALV, "jal_jal");

    // Asynchronous reset in the middle of MEM_RD
    step(OP_LW, 1'b1, F_R,   "rst_lw_fetch");
    step(OP_LW, 1'b0, DEC,   "rst_lw_decode");
    step(OP_LW, 1'b0, MADDR, "rst_lw_addr");
    step(OP_LW, 1'b0, MRD,   "rst_lw_rd");
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", Z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(OP_LW, 1'b0, Z,   "rst_after_rst");
    step(OP_LW, 1'b0, F_W, "rst_after_fetch");

    // Timeout: 15 waiting FETCH cycles, then TRAP with BusErr
    do_reset();
    step(7'd0, 1'b0, Z, "to_rst");
    for (int i = 0; i < 15; i++) step(OP_R, 1'b0, F_W, "to_fetch_wait");
    step(OP_R, 1'b1, TRAP_B, "to_trap");
    step(OP_R, 1'b1, TRAP_B, "to_trap_hold");
    step(OP_R, 1'b0, TRAP_B, "to_trap_hold");

    // MemReady in the 15th waiting cycle still wins
    do_reset();
    step(7'd0, 1'b0, Z, "edge_rst");
    for (int i = 0; i < 14; i++) step(OP_R, 1'b0, F_W, "edge_fetch_wait");
    step(OP_R, 1'b1, F_R, "edge_fetch_ready");
    step(OP_R, 1'b0, DEC, "edge_decode");
    step(OP_R, 1'b0, EXR, "edge_exec");
    step(OP_R, 1'b0, WBA, "edge_wb");

    // Illegal opcode: sticky trap, no enables for 20 cycles
    step(OP_ILL, 1'b1, F_R, "ill_fetch");
    step(OP_ILL, 1'b0, DEC, "ill_decode");
    for (int i = 0; i < 20; i++) step(OP_SW, 1'(i % 2), TRAP_I, "ill_trap");

    do_reset();
    step(7'd0, 1'b0, Z,   "clr_rst");
    step(OP_R, 1'b0, F_W, "clr_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
